// File: rtl/hc08_selftest_seq.sv
// Self-test sequencer for a quad 2-input AND device (74HC08 pattern).
// Walks all four gates through the four input vectors together. Each vector is
// held for SETTLE+1 cycles, and the synchronised outputs are compared against a&b.
// The run result (pass, per-gate fail mask, first failing vector) is reported
// once per completed run.
`timescale 1ns/1ps

module hc08_selftest_seq #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] y,
    output logic [3:0] pa,
    output logic [3:0] pb,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] fail_vec,
    output logic [7:0] run_cnt
);

    typedef enum logic [0:0] {StIdle, StDrive} state_t;

    localparam logic [7:0] SettleCnt = 8'(SETTLE);

    state_t     state;
    logic [1:0] vec;
    logic [7:0] cnt;
    logic [3:0] y_m;
    logic [3:0] y_s;
    logic [3:0] work_mask;
    logic [1:0] first_vec;

    logic [3:0] exp_y;
    logic [3:0] mism;
    logic [3:0] new_mask;
    logic [1:0] new_first;
    logic [1:0] next_vec;

    // Two-flop synchroniser for the asynchronous device outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_m <= 4'b0000;
            y_s <= 4'b0000;
        end else begin
            y_m <= y;
            y_s <= y_m;
        end
    end

    // Expected value, mismatch and the accumulated result for the current sample.
    always_comb begin
        exp_y    = {4{vec[1] & vec[0]}};
        mism     = y_s ^ exp_y;
        new_mask = work_mask | mism;
        next_vec = vec + 2'd1;
        // An empty working mask means no earlier mismatch in this run.
        if ((work_mask == 4'b0000) && (mism != 4'b0000)) begin
            new_first = vec;
        end else begin
            new_first = first_vec;
        end
    end

    // Sequencer FSM with registered pin drive and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            vec       <= 2'd0;
            cnt       <= 8'd0;
            pa        <= 4'b0000;
            pb        <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'b0000;
            fail_vec  <= 2'd0;
            run_cnt   <= 8'd0;
            work_mask <= 4'b0000;
            first_vec <= 2'd0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    pa   <= 4'b0000;
                    pb   <= 4'b0000;
                    if (start) begin
                        state     <= StDrive;
                        vec       <= 2'd0;
                        cnt       <= 8'd0;
                        busy      <= 1'b1;
                        work_mask <= 4'b0000;
                        first_vec <= 2'd0;
                    end
                end
                StDrive: begin
                    if (cnt == SettleCnt) begin
                        work_mask <= new_mask;
                        first_vec <= new_first;
                        cnt       <= 8'd0;
                        if (vec == 2'd3) begin
                            state     <= StIdle;
                            vec       <= 2'd0;
                            pa        <= 4'b0000;
                            pb        <= 4'b0000;
                            fail_mask <= new_mask;
                            fail_vec  <= new_first;
                            pass      <= (new_mask == 4'b0000);
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            if (run_cnt != 8'd255) begin
                                run_cnt <= run_cnt + 8'd1;
                            end
                        end else begin
                            vec <= next_vec;
                            pa  <= {4{next_vec[1]}};
                            pb  <= {4{next_vec[0]}};
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
